// File: rtl/kmeans_assign_engine.sv
// K-means assignment engine: nearest-mean labelling (L1 / L-infinity)
// with per-cluster channel accumulators and pixel counters.
module kmeans_assign_engine #(
    parameter int K    = 16,
    parameter int NCH  = 3,
    parameter int CW   = 8,
    parameter int CNTW = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            metric,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NCH*CW-1:0]               pixel_in,
    input  logic [K*NCH*CW-1:0]             means_in,
    input  logic [K-1:0]                    enable,
    output logic                            lbl_valid,
    output logic [$clog2(K)-1:0]            lbl_idx,
    output logic [CW+1:0]                   lbl_dist,
    output logic [K*NCH*(CW+CNTW)-1:0]      acc_out,
    output logic [K*CNTW-1:0]               cnt_out,
    output logic [15:0]                     dropped,
    output logic                            overflow,
    output logic                            busy
);
    localparam int DW = CW + 2;
    localparam int AW = CW + CNTW;
    localparam int IW = $clog2(K);
    localparam int PW = NCH * CW;

    logic            cap_v, cap_met;
    logic [PW-1:0]   cap_pix;
    logic [K-1:0]    cap_en;
    logic            dst_v;
    logic [PW-1:0]   dst_pix;
    logic [K-1:0]    dst_en;
    logic [K*DW-1:0] dst_d;
    logic            lab_v;
    logic [PW-1:0]   lab_pix;

    logic [K*DW-1:0] dist_c;
    logic            found;
    logic [IW-1:0]   best_i;
    logic [DW-1:0]   best_d;
    logic [CNTW-1:0] cnt_sel;

    assign in_ready = !clear;
    assign busy     = cap_v | dst_v | lab_v;
    assign cnt_sel  = cnt_out[int'(lbl_idx)*CNTW +: CNTW];

    // S1: per-cluster distance against the live means.
    always_comb begin
        logic [CW-1:0] p, m, ad;
        logic [DW-1:0] d;
        dist_c = '0;
        p = '0;
        m = '0;
        ad = '0;
        d = '0;
        for (int i = 0; i < K; i++) begin
            d = '0;
            for (int c = 0; c < NCH; c++) begin
                p  = cap_pix[c*CW +: CW];
                m  = means_in[(i*NCH+c)*CW +: CW];
                ad = (p > m) ? p - m : m - p;
                if (cap_met)
                    d = (DW'(ad) > d) ? DW'(ad) : d;
                else
                    d = d + DW'(ad);
            end
            dist_c[i*DW +: DW] = d;
        end
    end

    // S2: strict less-than keeps the lowest index on ties.
    always_comb begin
        found  = 1'b0;
        best_i = '0;
        best_d = '0;
        for (int i = 0; i < K; i++) begin
            if (dst_en[i] && (!found || dst_d[i*DW +: DW] < best_d)) begin
                found  = 1'b1;
                best_i = IW'(i);
                best_d = dst_d[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_v     <= 1'b0;
            cap_met   <= 1'b0;
            cap_pix   <= '0;
            cap_en    <= '0;
            dst_v     <= 1'b0;
            dst_pix   <= '0;
            dst_en    <= '0;
            dst_d     <= '0;
            lab_v     <= 1'b0;
            lab_pix   <= '0;
            lbl_valid <= 1'b0;
            lbl_idx   <= '0;
            lbl_dist  <= '0;
        end else begin
            cap_v <= in_valid && !clear;
            if (in_valid && !clear) begin
                cap_pix <= pixel_in;
                cap_met <= metric;
                cap_en  <= enable;
            end
            dst_v     <= cap_v && !clear;
            dst_pix   <= cap_pix;
            dst_en    <= cap_en;
            dst_d     <= dist_c;
            lab_v     <= dst_v && !clear;
            lbl_valid <= dst_v && found && !clear;
            lbl_idx   <= best_i;
            lbl_dist  <= best_d;
            lab_pix   <= dst_pix;
        end
    end

    // S3: a saturated counter freezes its accumulators too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out  <= '0;
            cnt_out  <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            acc_out  <= '0;
            cnt_out  <= '0;
            dropped  <= '0;
            overflow <= 1'b0;
        end else begin
            if (lbl_valid) begin
                if (cnt_sel == {CNTW{1'b1}}) begin
                    overflow <= 1'b1;
                end else begin
                    cnt_out[int'(lbl_idx)*CNTW +: CNTW] <= cnt_sel + CNTW'(1);
                    for (int c = 0; c < NCH; c++)
                        acc_out[(int'(lbl_idx)*NCH+c)*AW +: AW] <=
                            acc_out[(int'(lbl_idx)*NCH+c)*AW +: AW] +
                            AW'(lab_pix[c*CW +: CW]);
                end
            end
            if (lab_v && !lbl_valid && dropped != 16'hFFFF)
                dropped <= dropped + 16'd1;
        end
    end
endmodule

// File: tb/tb_kmeans_assign_engine.sv
// Directed bench for kmeans_assign_engine: latency, metrics, ties,
// enable masking, saturation, mid-stream clear and async reset.
module tb_kmeans_assign_engine;
    localparam int K = 8, NCH = 3, CW = 8, CNTW = 4;
    localparam int AW = CW + CNTW;

    logic                   clk = 1'b0;
    logic                   reset, clear, metric, in_valid, in_ready;
    logic [NCH*CW-1:0]      pixel_in;
    logic [K*NCH*CW-1:0]    means_in;
    logic [K-1:0]           enable;
    logic                   lbl_valid;
    logic [2:0]             lbl_idx;
    logic [CW+1:0]          lbl_dist;
    logic [K*NCH*AW-1:0]    acc_out;
    logic [K*CNTW-1:0]      cnt_out;
    logic [15:0]            dropped;
    logic                   overflow, busy;

    int n_chk = 0;
    int n_err = 0;
    int lq_idx[$];
    int lq_dist[$];

    kmeans_assign_engine #(.K(K), .NCH(NCH), .CW(CW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .metric(metric),
        .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
        .means_in(means_in), .enable(enable), .lbl_valid(lbl_valid),
        .lbl_idx(lbl_idx), .lbl_dist(lbl_dist), .acc_out(acc_out),
        .cnt_out(cnt_out), .dropped(dropped), .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lbl_valid) begin
            lq_idx.push_back(int'(lbl_idx));
            lq_dist.push_back(int'(lbl_dist));
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(cnt_out[i*CNTW +: CNTW]);
    endfunction

    function automatic logic [31:0] acc_of(input int i, input int c);
        return 32'(acc_out[(i*NCH+c)*AW +: AW]);
    endfunction

    function automatic logic [23:0] pix3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic set_mean(input int i, input int a, input int b, input int c);
        means_in[i*24 +: 24] = pix3(a, b, c);
    endtask

    task automatic clear_epoch();
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        #1 check("in_ready_clear", 32'(in_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        lq_idx.delete();
        lq_dist.delete();
    endtask

    task automatic send(input logic [23:0] p, input logic m, input logic [7:0] e);
        in_valid = 1'b1;
        pixel_in = p;
        metric = m;
        enable = e;
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        metric = 1'b0;
        in_valid = 1'b0;
        pixel_in = '0;
        means_in = '0;
        enable = '0;
        #3;
        check("rst_lbl_valid", 32'(lbl_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dropped", 32'(dropped), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_acc", 32'(|acc_out), 0);
        check("rst_cnt", 32'(|cnt_out), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Basic L1 with cycle-exact latency
        clear_epoch();
        set_mean(0, 0, 0, 0);
        set_mean(1, 100, 100, 100);
        set_mean(2, 200, 200, 200);
        set_mean(3, 255, 255, 255);
        send(pix3(90, 95, 110), 1'b0, 8'h0F);
        in_valid = 1'b0;
        check("b_busy_n", 32'(busy), 1);
        check("b_lv_n", 32'(lbl_valid), 0);
        @(negedge clk);
        check("b_lv_n1", 32'(lbl_valid), 0);
        @(negedge clk);
        check("b_lv_n2", 32'(lbl_valid), 1);
        check("b_idx", 32'(lbl_idx), 1);
        check("b_dist", 32'(lbl_dist), 25);
        check("b_cnt_n2", cnt_of(1), 0);
        @(negedge clk);
        check("b_lv_n3", 32'(lbl_valid), 0);
        check("b_cnt1", cnt_of(1), 1);
        check("b_acc1_0", acc_of(1, 0), 90);
        check("b_acc1_1", acc_of(1, 1), 95);
        check("b_acc1_2", acc_of(1, 2), 110);
        check("b_busy_n3", 32'(busy), 0);

        // L1 vs L-infinity divergence
        clear_epoch();
        set_mean(0, 0, 0, 30);
        set_mean(1, 20, 20, 20);
        send(pix3(0, 0, 0), 1'b0, 8'h03);
        send(pix3(0, 0, 0), 1'b1, 8'h03);
        drain();
        check("m_nlab", 32'(lq_idx.size()), 2);
        check("m_l1_idx", 32'(lq_idx[0]), 0);
        check("m_l1_dist", 32'(lq_dist[0]), 30);
        check("m_li_idx", 32'(lq_idx[1]), 1);
        check("m_li_dist", 32'(lq_dist[1]), 20);
        check("m_cnt0", cnt_of(0), 1);
        check("m_cnt1", cnt_of(1), 1);

        // Ties and enable masking
        clear_epoch();
        for (int i = 0; i < K; i++) set_mean(i, 200, 200, 200);
        set_mean(0, 0, 0, 0);
        set_mean(2, 50, 50, 50);
        set_mean(5, 70, 70, 70);
        send(pix3(60, 60, 60), 1'b0, 8'hFF);
        send(pix3(60, 60, 60), 1'b0, 8'hFB);
        send(pix3(60, 60, 60), 1'b0, 8'h00);
        drain();
        check("t_nlab", 32'(lq_idx.size()), 2);
        check("t_idx_tie", 32'(lq_idx[0]), 2);
        check("t_dist_tie", 32'(lq_dist[0]), 30);
        check("t_idx_mask", 32'(lq_idx[1]), 5);
        check("t_dropped", 32'(dropped), 1);
        check("t_cnt2", cnt_of(2), 1);
        check("t_cnt5", cnt_of(5), 1);

        // Counter saturation
        clear_epoch();
        check("s_dropped_clr", 32'(dropped), 0);
        set_mean(0, 10, 10, 10);
        for (int n = 0; n < 20; n++) send(pix3(10, 10, 10), 1'b0, 8'h01);
        drain();
        check("s_nlab", 32'(lq_idx.size()), 20);
        check("s_cnt0", cnt_of(0), 15);
        check("s_acc0_0", acc_of(0, 0), 150);
        check("s_acc0_2", acc_of(0, 2), 150);
        check("s_overflow", 32'(overflow), 1);

        // Clear on the 5th acceptance edge
        clear_epoch();
        check("c_overflow_clr", 32'(overflow), 0);
        set_mean(0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            pixel_in = pix3(k, k, k);
            metric = 1'b0;
            enable = 8'h01;
            clear = (k == 5);
            if (k == 5) #1 check("c_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        clear = 1'b0;
        drain();
        check("c_nlab", 32'(lq_idx.size()), 5);
        check("c_dist1", 32'(lq_dist[1]), 6);
        check("c_dist2", 32'(lq_dist[2]), 18);
        check("c_cnt0", cnt_of(0), 3);
        check("c_acc0", acc_of(0, 1), 21);

        // Asynchronous reset between edges
        send(pix3(1, 1, 1), 1'b0, 8'h01);
        send(pix3(2, 2, 2), 1'b0, 8'h01);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("r_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("r_busy", 32'(busy), 0);
        check("r_lbl_valid", 32'(lbl_valid), 0);
        check("r_cnt", 32'(|cnt_out), 0);
        check("r_acc", 32'(|acc_out), 0);
        @(negedge clk);
        reset = 1'b0;
        check("r_in_ready", 32'(in_ready), 1);
        send(pix3(4, 4, 4), 1'b0, 8'h01);
        drain();
        check("r_cnt0_after", cnt_of(0), 1);
        check("r_acc0_after", acc_of(0, 0), 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
